stopwatch_bcd_core: RTL and testbench

//  MM:SS.hh stopwatch. Consumes the 100 Hz and 1 kHz square waves from the 50 MHz divider stage.

---
 rtl/stopwatch_bcd_core.sv | 238 +++++++++++++++++++++++
 tb/tb_stopwatch_bcd_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_core.sv
// MM:SS.hh stopwatch core: tick recovery, key debounce, run/pause FSM,
// saturating BCD time base and a 6-digit multiplexed 7-segment driver.
module stopwatch_bcd_core #(
  parameter int MAX_MIN        = 59,
  parameter int DEB_MS         = 20,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       CLK_50M,
  input  logic       nCLR,
  input  logic       TICK_100Hz,
  input  logic       TICK_1kHz,
  input  logic       KEY_SS_n,
  input  logic       KEY_CLR_n,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic [7:0] HUN_BCD,
  output logic       RUNNING,
  output logic       OVF,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [5:0] AN
);

  localparam int              DEB_W    = $clog2(DEB_MS + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MS - 1);
  localparam logic [3:0]      MAX_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]      MAX_U    = 4'(MAX_MIN % 10);
  localparam logic            POL      = (SEG_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t state_q, state_d;
  logic t100_s1, t100_s2, t1k_s1, t1k_s2;
  logic tick100, tick1k;
  logic [1:0] key_raw, key_s1, key_s2, key_lvl, press;
  logic [DEB_W-1:0] deb_cnt [2];
  logic ss_press, clr_press;
  logic [3:0] hu, ht, su, st, mu, mt;
  logic at_max, cnt_inc, cnt_zero, ovf_set, ovf_q;
  logic [2:0] scan_idx;
  logic [3:0] scan_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    seg_pol = POL ? ~s : s;
  endfunction

  // Synchronise the divider square waves; rising edges become 1-cycle pulses.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      t100_s1 <= 1'b0;
      t100_s2 <= 1'b0;
      t1k_s1  <= 1'b0;
      t1k_s2  <= 1'b0;
    end else begin
      t100_s1 <= TICK_100Hz;
      t100_s2 <= t100_s1;
      t1k_s1  <= TICK_1kHz;
      t1k_s2  <= t1k_s1;
    end
  end

  assign tick100 = t100_s1 & ~t100_s2;
  assign tick1k  = t1k_s1 & ~t1k_s2;

  // Key synchronisers and per-key run-length debounce sampled at 1 kHz.
  assign key_raw = {KEY_CLR_n, KEY_SS_n};

  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      key_s1     <= 2'b00;
      key_s2     <= 2'b00;
      key_lvl    <= 2'b11;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      if (tick1k) begin
        for (int k = 0; k < 2; k++) begin
          if (key_s2[k] != key_lvl[k]) begin
            if (deb_cnt[k] == DEB_LAST) begin
              key_lvl[k] <= key_s2[k];
              deb_cnt[k] <= '0;
            end else begin
              deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
          end else begin
            deb_cnt[k] <= '0;
          end
        end
      end
    end
  end

  // A press is the cycle in which a key's stable level falls to 0.
  always_comb begin
    press = 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (tick1k && (key_s2[k] != key_lvl[k]) && (deb_cnt[k] == DEB_LAST) && !key_s2[k])
        press[k] = 1'b1;
    end
  end

  assign ss_press  = press[0];
  assign clr_press = press[1];

  assign at_max = (mt == MAX_T) && (mu == MAX_U) && (st == 4'd5) && (su == 4'd9) &&
                  (ht == 4'd9) && (hu == 4'd9);

  // FSM state register.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and count controls; clr beats ss in PAUSE, overflow locks PAUSE.
  always_comb begin
    state_d  = state_q;
    cnt_inc  = 1'b0;
    cnt_zero = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: if (ss_press) state_d = RUN;
      RUN: begin
        if (tick100) begin
          if (at_max) begin
            ovf_set = 1'b1;
            state_d = PAUSE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        if (ss_press) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_press) begin
          state_d  = IDLE;
          cnt_zero = 1'b1;
        end else if (ss_press && !ovf_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BCD time base with digit-wise carries, plus the sticky overflow flag.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      {mt, mu, st, su, ht, hu} <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_zero) begin
      {mt, mu, st, su, ht, hu} <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (cnt_inc) begin
        if (hu == 4'd9) begin
          hu <= 4'd0;
          if (ht == 4'd9) begin
            ht <= 4'd0;
            if (su == 4'd9) begin
              su <= 4'd0;
              if (st == 4'd5) begin
                st <= 4'd0;
                if (mu == 4'd9) begin
                  mu <= 4'd0;
                  mt <= mt + 4'd1;
                end else begin
                  mu <= mu + 4'd1;
                end
              end else begin
                st <= st + 4'd1;
              end
            end else begin
              su <= su + 4'd1;
            end
          end else begin
            ht <= ht + 4'd1;
          end
        end else begin
          hu <= hu + 4'd1;
        end
      end
    end
  end

  assign MIN_BCD = {mt, mu};
  assign SEC_BCD = {st, su};
  assign HUN_BCD = {ht, hu};
  assign RUNNING = (state_q == RUN);
  assign OVF     = ovf_q;

  // Select the digit for the current scan position.
  always_comb begin
    case (scan_idx)
      3'd0:    scan_digit = hu;
      3'd1:    scan_digit = ht;
      3'd2:    scan_digit = su;
      3'd3:    scan_digit = st;
      3'd4:    scan_digit = mu;
      3'd5:    scan_digit = mt;
      default: scan_digit = hu;
    endcase
  end

  // Advance the scan on each 1 kHz pulse and register the display drive.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      scan_idx <= 3'd0;
      AN       <= 6'b111110;
      SEG      <= seg_pol(7'h3F);
      DP       <= POL;
    end else begin
      if (tick1k) scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
      AN  <= ~(6'd1 << scan_idx);
      SEG <= seg_pol(seg_decode(scan_digit));
      DP  <= POL ^ ((scan_idx == 3'd2) || (scan_idx == 3'd4));
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Bench for stopwatch_bcd_core: randomized ticks/keys against a behavioural
// model that tracks elapsed time as an integer count of hundredths.
module tb_stopwatch_bcd_core;

  localparam int MAXM = 1;
  localparam int DEB  = 20;
  localparam int TMAX = MAXM * 6000 + 5999;

  logic clk = 1'b0;
  logic nclr, tk100, tk1k, kss, kclr;
  logic [7:0] min_bcd, sec_bcd, hun_bcd;
  logic running, ovf, dp;
  logic [6:0] seg;
  logic [5:0] an;

  int total = 0;
  int bad   = 0;

  stopwatch_bcd_core #(.MAX_MIN(MAXM), .DEB_MS(DEB), .SEG_ACTIVE_LOW(1)) dut (
    .CLK_50M(clk), .nCLR(nclr), .TICK_100Hz(tk100), .TICK_1kHz(tk1k),
    .KEY_SS_n(kss), .KEY_CLR_n(kclr), .MIN_BCD(min_bcd), .SEC_BCD(sec_bcd),
    .HUN_BCD(hun_bcd), .RUNNING(running), .OVF(ovf), .SEG(seg), .DP(dp), .AN(an)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [5:0] an_exp [6]  = '{6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};

  // mode: 0 idle, 1 run, 2 pause; t: elapsed hundredths; a/b/s/c: input history
  typedef struct packed {
    int mode; int t; logic ovf; int idx;
    logic lss; int css; logic lclr; int cclr;
    logic a1, a2, b1, b2, s1, s2, c1, c2;
    logic [5:0] an; logic [6:0] seg; logic dp;
  } m_t;

  m_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic m_t reset_m();
    m_t r;
    r = '0;
    r.lss = 1'b1; r.lclr = 1'b1;
    r.an = 6'h3E; r.seg = ~7'h3F; r.dp = 1'b1;
    return r;
  endfunction

  function automatic int digit(input int t, input int i);
    int h, s, mn;
    h = t % 100; s = (t / 100) % 60; mn = t / 6000;
    case (i)
      0: return h % 10;
      1: return h / 10;
      2: return s % 10;
      3: return s / 10;
      4: return mn % 10;
      default: return mn / 10;
    endcase
  endfunction

  function automatic logic [7:0] bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic m_t step(input m_t c, input logic i100, input logic i1k,
                              input logic iss, input logic iclr);
    m_t n;
    logic e100, e1k, pss, pclr;
    n = c;
    e100 = c.a1 & ~c.a2;
    e1k  = c.b1 & ~c.b2;
    n.a1 = i100; n.a2 = c.a1; n.b1 = i1k; n.b2 = c.b1;
    n.s1 = iss;  n.s2 = c.s1; n.c1 = iclr; n.c2 = c.c1;
    n.an  = ~(6'd1 << c.idx);
    n.seg = ~segtab[digit(c.t, c.idx)];
    n.dp  = !(c.idx == 2 || c.idx == 4);
    pss = 1'b0; pclr = 1'b0;
    if (e1k) begin
      if (c.s2 != c.lss) begin
        if (c.css + 1 == DEB) begin n.lss = c.s2; n.css = 0; pss = !c.s2; end
        else n.css = c.css + 1;
      end else n.css = 0;
      if (c.c2 != c.lclr) begin
        if (c.cclr + 1 == DEB) begin n.lclr = c.c2; n.cclr = 0; pclr = !c.c2; end
        else n.cclr = c.cclr + 1;
      end else n.cclr = 0;
      n.idx = (c.idx + 1) % 6;
    end
    case (c.mode)
      0: if (pss) n.mode = 1;
      1: begin
        if (e100) begin
          if (c.t == TMAX) begin n.ovf = 1'b1; n.mode = 2; end
          else n.t = c.t + 1;
        end
        if (pss) n.mode = 2;
      end
      default: begin
        if (pclr) begin n.mode = 0; n.t = 0; n.ovf = 1'b0; end
        else if (pss && !c.ovf) n.mode = 1;
      end
    endcase
    return n;
  endfunction

  // Reference model update.
  always @(posedge clk or negedge nclr) begin
    if (!nclr) m <= reset_m();
    else       m <= step(m, tk100, tk1k, kss, kclr);
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    chk("min", min_bcd, bcd(m.t / 6000));
    chk("sec", sec_bcd, bcd((m.t / 100) % 60));
    chk("hun", hun_bcd, bcd(m.t % 100));
    chk("running", running, m.mode == 1);
    chk("ovf", ovf, m.ovf);
    chk("seg", seg, m.seg);
    chk("dp", dp, m.dp);
    chk("an", an, m.an);
  end

  // Free-running 1 kHz stand-in with random phase jitter.
  initial begin
    tk1k = 1'b0;
    forever begin
      @(negedge clk);
      if ($urandom_range(3) != 0) tk1k = ~tk1k;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      tk100 = 1'b1; @(negedge clk);
      tk100 = 1'b0; @(negedge clk);
    end
    cyc(2);
  endtask

  // which: 0 = start/stop, 1 = clear, 2 = both together
  task automatic press(input int which);
    bit ok;
    if (which != 1) kss = 1'b0;
    if (which != 0) kclr = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 1 || !m.lss) && (which == 0 || !m.lclr)) begin ok = 1'b1; break; end
    end
    chk("press_settle", ok, 1);
    cyc(4);
    kss = 1'b1; kclr = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m.lss && m.lclr) begin ok = 1'b1; break; end
    end
    chk("release_settle", ok, 1);
  endtask

  task automatic chk_time(input string nm, input logic [7:0] mn, input logic [7:0] s,
                          input logic [7:0] h);
    chk({nm, "_min"}, min_bcd, mn);
    chk({nm, "_sec"}, sec_bcd, s);
    chk({nm, "_hun"}, hun_bcd, h);
  endtask

  initial begin
    logic [5:0] prev;
    logic [5:0] seen [$];
    nclr = 1'b0; tk100 = 1'b0; kss = 1'b1; kclr = 1'b1;
    cyc(3);
    chk_time("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_running", running, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_an", an, 6'h3E);
    chk("reset_seg", seg, 7'h40);
    chk("reset_dp", dp, 1);
    nclr = 1'b1;

    // Idle with ticks: nothing counts, scan walks through all six digits.
    prev = 6'h3E;
    for (int i = 0; i < 200 && seen.size() < 6; i++) begin
      tk100 = (i < 20) ? ~tk100 : 1'b0;
      @(negedge clk);
      if (an !== prev) begin seen.push_back(an); prev = an; end
    end
    tk100 = 1'b0;
    chk("scan_len", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("scan_seq", seen[i], an_exp[i]);
    chk_time("idle", 8'h00, 8'h00, 8'h00);
    chk("idle_running", running, 0);

    // Start, then 123 hundredths.
    press(0);
    chk("start_running", running, 1);
    pulses(123);
    chk_time("run123", 8'h00, 8'h01, 8'h23);

    // Bouncing key collapses to one press: RUN -> PAUSE once.
    for (int i = 0; i < 5; i++) begin
      kss = 1'b0; cyc(6);
      kss = 1'b1; cyc(6);
    end
    chk("bounce_running", running, 1);
    press(0);
    chk("bounce_paused", running, 0);
    chk_time("bounce", 8'h00, 8'h01, 8'h23);

    // Clear ignored in RUN; simultaneous ss+clr in PAUSE clears.
    press(0);
    press(1);
    chk("clr_in_run", running, 1);
    chk_time("clr_in_run", 8'h00, 8'h01, 8'h23);
    press(0);
    press(2);
    chk("both_running", running, 0);
    chk("both_ovf", ovf, 0);
    chk_time("both", 8'h00, 8'h00, 8'h00);

    // Carry into minutes, then saturation at MAX_MIN:59.99.
    press(0);
    pulses(5999);
    chk_time("pre_carry", 8'h00, 8'h59, 8'h99);
    pulses(1);
    chk_time("carry", 8'h01, 8'h00, 8'h00);
    pulses(5999);
    chk_time("pre_max", 8'h01, 8'h59, 8'h99);
    chk("pre_max_ovf", ovf, 0);
    pulses(1);
    chk_time("sat", 8'h01, 8'h59, 8'h99);
    chk("sat_ovf", ovf, 1);
    chk("sat_running", running, 0);
    pulses(5);
    press(0);
    chk("ovf_ss_ignored", running, 0);
    press(1);
    chk("ovf_cleared", ovf, 0);
    chk_time("ovf_clr", 8'h00, 8'h00, 8'h00);

    // Random ticks and key activity against the model.
    for (int i = 0; i < 6000; i++) begin
      tk100 = 1'($urandom_range(1));
      if ($urandom_range(79) == 0) kss = ~kss;
      if ($urandom_range(79) == 0) kclr = ~kclr;
      @(negedge clk);
    end
    kss = 1'b1; kclr = 1'b1; tk100 = 1'b0;
    cyc(200);

    // Asynchronous reset mid-run at 00:12.34.
    nclr = 1'b0; cyc(2); nclr = 1'b1; cyc(2);
    press(0);
    pulses(1234);
    chk_time("mid", 8'h00, 8'h12, 8'h34);
    chk("mid_running", running, 1);
    #2 nclr = 1'b0;
    #1;
    chk_time("async", 8'h00, 8'h00, 8'h00);
    chk("async_running", running, 0);
    chk("async_an", an, 6'h3E);
    @(negedge clk);
    #2 nclr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tk100 = 1'($urandom_range(1));
      @(negedge clk);
    end
    tk100 = 1'b0;
    cyc(2);
    chk("post_rst_running", running, 0);
    chk_time("post_rst", 8'h00, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
